// File: rtl/pipeline_bus_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_bus_pkg : shared encodings for the IF/MEM bus arbiter
// Rev 1.0
// ============================================================================
package pipeline_bus_pkg;

    localparam int CTRL_W = 3;

    // Instruction fetches are always full doubleword reads.
    localparam logic [CTRL_W-1:0] IF_RD_CTRL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_DM = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// bus_timeout_counter : counts cycles of an outstanding bus access
// Rev 1.0
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count never needs to exceed TIMEOUT-1: that value marks the last cycle.
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_bus_arbiter.sv
`default_nettype none
// ============================================================================
// pipeline_bus_arbiter : shares one memory bus between IF and the MEM stage
// Rev 1.0
// ============================================================================
module pipeline_bus_arbiter
    import pipeline_bus_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int TIMEOUT  = 15,
    parameter int DM_BURST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic [CTRL_W-1:0] dm_rd_ctrl,
    input  logic [CTRL_W-1:0] dm_wr_ctrl,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_din,
    output logic [DATA_W-1:0] dm_dout,
    output logic              dm_ready,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [CTRL_W-1:0] bus_rd_ctrl,
    output logic [CTRL_W-1:0] bus_wr_ctrl,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int STREAK_W = $clog2(DM_BURST + 1);

    arb_state_e          state_q, state_d;
    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [CTRL_W-1:0]   bus_rd_ctrl_q, bus_rd_ctrl_d;
    logic [CTRL_W-1:0]   bus_wr_ctrl_q, bus_wr_ctrl_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   dm_dout_q, dm_dout_d;
    logic                dm_ready_q, dm_ready_d;
    logic                bus_err_q, bus_err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic dm_req;
    logic if_pend;
    logic dm_pend;
    logic streak_full;
    logic grant_if;
    logic grant_dm;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    // A requester whose ready is pulsing still shows its old, already-served request.
    assign dm_req      = (|dm_rd_ctrl) | (|dm_wr_ctrl);
    assign if_pend     = if_req & ~if_ready_q;
    assign dm_pend     = dm_req & ~dm_ready_q;
    assign streak_full = (streak_q == STREAK_W'(DM_BURST));

    assign timer_en    = (state_q != ST_IDLE);
    assign timer_clear = (state_q == ST_IDLE) || (state_d != state_q);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        bus_valid_d   = bus_valid_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_rd_ctrl_d = bus_rd_ctrl_q;
        bus_wr_ctrl_d = bus_wr_ctrl_q;
        if_rdata_d    = if_rdata_q;
        if_ready_d    = 1'b0;
        dm_dout_d     = dm_dout_q;
        dm_ready_d    = 1'b0;
        bus_err_d     = 1'b0;
        grant_if      = 1'b0;
        grant_dm      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dm_pend && !(if_pend && streak_full)) begin
                    grant_dm = 1'b1;
                end else if (if_pend) begin
                    grant_if = 1'b1;
                end
            end
            ST_GNT_IF: begin
                if (bus_ack || timer_expired) begin
                    if_rdata_d  = bus_ack ? bus_rdata : '0;
                    if_ready_d  = 1'b1;
                    bus_err_d   = ~bus_ack;
                    bus_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    grant_dm    = bus_ack & dm_pend;
                end
            end
            ST_GNT_DM: begin
                if (bus_ack || timer_expired) begin
                    dm_dout_d   = (bus_ack && (bus_wr_ctrl_q == '0)) ? bus_rdata : '0;
                    dm_ready_d  = 1'b1;
                    bus_err_d   = ~bus_ack;
                    bus_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    grant_if    = bus_ack & if_pend;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_dm) begin
            state_d       = ST_GNT_DM;
            bus_valid_d   = 1'b1;
            bus_addr_d    = dm_addr;
            bus_wdata_d   = dm_din;
            bus_rd_ctrl_d = dm_rd_ctrl;
            bus_wr_ctrl_d = dm_wr_ctrl;
        end else if (grant_if) begin
            state_d       = ST_GNT_IF;
            bus_valid_d   = 1'b1;
            bus_addr_d    = if_addr;
            bus_wdata_d   = '0;
            bus_rd_ctrl_d = IF_RD_CTRL;
            bus_wr_ctrl_d = '0;
        end

        if (!if_req || grant_if) begin
            streak_d = '0;
        end else if (grant_dm && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bus_valid_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_rd_ctrl_q <= '0;
            bus_wr_ctrl_q <= '0;
            if_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            dm_dout_q     <= '0;
            dm_ready_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            streak_q      <= '0;
        end else begin
            state_q       <= state_d;
            bus_valid_q   <= bus_valid_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_rd_ctrl_q <= bus_rd_ctrl_d;
            bus_wr_ctrl_q <= bus_wr_ctrl_d;
            if_rdata_q    <= if_rdata_d;
            if_ready_q    <= if_ready_d;
            dm_dout_q     <= dm_dout_d;
            dm_ready_q    <= dm_ready_d;
            bus_err_q     <= bus_err_d;
            streak_q      <= streak_d;
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_rd_ctrl = bus_rd_ctrl_q;
    assign bus_wr_ctrl = bus_wr_ctrl_q;
    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign dm_dout     = dm_dout_q;
    assign dm_ready    = dm_ready_q;
    assign bus_err     = bus_err_q;
    assign stall_if    = if_pend;
    assign stall_mem   = dm_pend;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pipeline_bus_arbiter : directed scenarios plus randomized traffic
// Rev 1.0
// ============================================================================
module tb_pipeline_bus_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int TIMEOUT  = 15;
    localparam int DM_BURST = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic [2:0]        dm_rd_ctrl = '0;
    logic [2:0]        dm_wr_ctrl = '0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_din = '0;
    logic [DATA_W-1:0] dm_dout;
    logic              dm_ready;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [2:0]        bus_rd_ctrl;
    logic [2:0]        bus_wr_ctrl;
    logic              bus_ack = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;
    logic              stall_if;
    logic              stall_mem;
    logic              bus_err;

    pipeline_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .DM_BURST (DM_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .dm_rd_ctrl  (dm_rd_ctrl),
        .dm_wr_ctrl  (dm_wr_ctrl),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_dout     (dm_dout),
        .dm_ready    (dm_ready),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rd_ctrl (bus_rd_ctrl),
        .bus_wr_ctrl (bus_wr_ctrl),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding access described as a transaction record.
    bit          m_busy;
    bit          m_who_dm;
    logic [63:0] m_addr, m_wdata;
    logic [2:0]  m_rd, m_wr;
    int          m_age;
    int          m_streak;
    bit          m_if_ready, m_dm_ready, m_err;
    logic [63:0] m_if_rdata, m_dm_dout;

    function automatic bit dm_req_in();
        return (dm_rd_ctrl != 3'b000) || (dm_wr_ctrl != 3'b000);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_who_dm = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_wr = '0;
        m_age = 0; m_streak = 0; m_if_ready = 0; m_dm_ready = 0; m_err = 0;
        m_if_rdata = '0; m_dm_dout = '0;
    endtask

    task automatic model_step();
        bit ifp, dmp, can_grant, gi, gd, done_ok;
        if (!reset) begin
            model_reset();
            return;
        end
        ifp = if_req && !m_if_ready;
        dmp = dm_req_in() && !m_dm_ready;
        can_grant = !m_busy;
        done_ok = 0;
        m_if_ready = 0; m_dm_ready = 0; m_err = 0;
        if (m_busy) begin
            if (bus_ack || m_age == TIMEOUT) begin
                if (m_who_dm) begin
                    m_dm_ready = 1;
                    m_dm_dout  = (bus_ack && m_wr == 3'b000) ? bus_rdata : 64'h0;
                end else begin
                    m_if_ready = 1;
                    m_if_rdata = bus_ack ? bus_rdata : 64'h0;
                end
                m_err  = !bus_ack;
                done_ok = bus_ack;
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
        // After a normal completion only the other requester may take the bus.
        gi = ifp && (can_grant || (done_ok && m_who_dm));
        gd = dmp && (can_grant || (done_ok && !m_who_dm));
        if (gi && gd) begin
            if (m_streak >= DM_BURST) gd = 0;
            else gi = 0;
        end
        if (!if_req || gi) m_streak = 0;
        else if (gd) m_streak = (m_streak + 1 > DM_BURST) ? DM_BURST : m_streak + 1;
        if (gd) begin
            m_busy = 1; m_who_dm = 1; m_age = 1;
            m_addr = dm_addr; m_wdata = dm_din; m_rd = dm_rd_ctrl; m_wr = dm_wr_ctrl;
        end else if (gi) begin
            m_busy = 1; m_who_dm = 0; m_age = 1;
            m_addr = if_addr; m_wdata = 64'h0; m_rd = 3'b111; m_wr = 3'b000;
        end
    endtask

    task automatic compare_regs();
        check_eq("bus_valid", bus_valid, m_busy);
        check_eq("if_ready", if_ready, m_if_ready);
        check_eq("dm_ready", dm_ready, m_dm_ready);
        check_eq("bus_err", bus_err, m_err);
        check_eq("if_rdata", if_rdata, m_if_rdata);
        check_eq("dm_dout", dm_dout, m_dm_dout);
        if (m_busy) begin
            check_eq("bus_addr", bus_addr, m_addr);
            check_eq("bus_wdata", bus_wdata, m_wdata);
            check_eq("bus_rd_ctrl", bus_rd_ctrl, m_rd);
            check_eq("bus_wr_ctrl", bus_wr_ctrl, m_wr);
        end
    endtask

    // Called just after a falling edge with inputs already set for the coming cycle.
    task automatic tick();
        #1;
        check_eq("stall_if", stall_if, if_req && !m_if_ready);
        check_eq("stall_mem", stall_mem, dm_req_in() && !m_dm_ready);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_regs();
    endtask

    task automatic idle_inputs();
        if_req = 0; dm_rd_ctrl = 0; dm_wr_ctrl = 0; bus_ack = 0;
    endtask

    initial begin
        int vcnt, grants, if_idx, ack_mode;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check_eq("rst_valid", bus_valid, 0);
        check_eq("rst_ready", if_ready | dm_ready, 0);
        compare_regs();
        tick();
        reset = 1;
        tick();

        // IF-only fetch, ack in the second valid cycle
        if_req = 1; if_addr = 64'h1000;
        tick();
        check_eq("t1_grant_addr", bus_addr, 64'h1000);
        check_eq("t1_grant_rd", bus_rd_ctrl, 3'b111);
        tick();
        bus_ack = 1; bus_rdata = 64'h13;
        tick();
        check_eq("t1_ready", if_ready, 1);
        check_eq("t1_rdata", if_rdata, 64'h13);
        idle_inputs();
        tick();
        check_eq("t1_hold", if_rdata, 64'h13);

        // IF and DM together: DM first, IF back-to-back
        if_req = 1; if_addr = 64'h1800; dm_rd_ctrl = 3'b011; dm_addr = 64'h2000;
        tick();
        check_eq("t2_dm_first", bus_addr, 64'h2000);
        bus_ack = 1; bus_rdata = 64'h55AA;
        tick();
        check_eq("t2_dm_ready", dm_ready, 1);
        check_eq("t2_b2b_valid", bus_valid, 1);
        check_eq("t2_b2b_addr", bus_addr, 64'h1800);
        dm_rd_ctrl = 0; bus_rdata = 64'h77;
        tick();
        check_eq("t2_if_ready", if_ready, 1);
        idle_inputs();
        tick();

        // Continuous DM traffic with IF waiting
        if_req = 1; if_addr = 64'h9000; dm_rd_ctrl = 3'b001; dm_addr = 64'h2100;
        bus_ack = 1; grants = 0; if_idx = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (m_busy && m_age == 1) begin
                grants++;
                if (bus_rd_ctrl == 3'b111 && if_idx == 0) if_idx = grants;
            end
            if (m_dm_ready) dm_addr = dm_addr + 64'h8;
            if (m_if_ready) if_req = 0;
            bus_rdata = {$urandom, $urandom};
        end
        check_eq("t3_if_by_3rd", (if_idx >= 1 && if_idx <= 3), 1);
        idle_inputs();
        tick();
        tick();

        // Timeout on a DM read
        dm_rd_ctrl = 3'b111; dm_addr = 64'h4000; vcnt = 0;
        for (int n = 0; n < 40 && !m_err; n++) begin
            tick();
            vcnt += int'(bus_valid);
        end
        check_eq("t4_err", bus_err, 1);
        check_eq("t4_ready", dm_ready, 1);
        check_eq("t4_dout", dm_dout, 0);
        check_eq("t4_valid_cycles", vcnt, TIMEOUT);
        dm_rd_ctrl = 0;
        tick();
        check_eq("t4_err_pulse", bus_err, 0);

        // Asynchronous reset in the middle of a DM access
        dm_rd_ctrl = 3'b001; dm_addr = 64'h5000;
        tick(); tick(); tick();
        reset = 0;
        #1;
        model_reset();
        check_eq("t5_valid", bus_valid, 0);
        check_eq("t5_dm_ready", dm_ready, 0);
        check_eq("t5_stall_mem", stall_mem, 1);
        compare_regs();
        @(negedge clk);
        dm_rd_ctrl = 0;
        tick();
        reset = 1;
        if_req = 1; if_addr = 64'h6000;
        tick();
        check_eq("t5_if_grant", bus_addr, 64'h6000);
        bus_ack = 1; bus_rdata = 64'hABCD;
        tick();
        check_eq("t5_if_rdata", if_rdata, 64'hABCD);
        idle_inputs();
        tick();

        // DM store held stable until ack
        dm_wr_ctrl = 3'b011; dm_addr = 64'h3000; dm_din = 64'hDEADBEEF;
        tick();
        for (int n = 0; n < 3; n++) begin
            tick();
            check_eq("t6_wdata", bus_wdata, 64'hDEADBEEF);
            check_eq("t6_wr", bus_wr_ctrl, 3'b011);
            check_eq("t6_addr", bus_addr, 64'h3000);
        end
        bus_ack = 1; bus_rdata = 64'hFFFF_1234;
        tick();
        check_eq("t6_ready", dm_ready, 1);
        check_eq("t6_dout", dm_dout, 0);
        idle_inputs();
        tick();

        // Randomized traffic
        ack_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            if (if_req && m_if_ready) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = {$urandom, $urandom} & ~64'h7;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = {$urandom, $urandom} & ~64'h7;
            end else if (if_req && $urandom_range(0, 49) == 0) begin
                if_req = 0;
            end
            if (dm_req_in() && m_dm_ready || !dm_req_in() && $urandom_range(0, 2) == 0) begin
                dm_addr = {$urandom, $urandom};
                dm_din  = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) begin
                    dm_rd_ctrl = 0; dm_wr_ctrl = 0;
                end else if ($urandom_range(0, 1) == 0) begin
                    dm_rd_ctrl = 3'($urandom_range(1, 7)); dm_wr_ctrl = 0;
                end else begin
                    dm_rd_ctrl = 0; dm_wr_ctrl = 3'($urandom_range(1, 7));
                end
            end else if (dm_req_in() && $urandom_range(0, 49) == 0) begin
                dm_rd_ctrl = 0; dm_wr_ctrl = 0;
            end
            if (m_busy) begin
                if (m_age == 1) ack_mode = $urandom_range(0, 9);
                bus_ack = (ack_mode == 0) ? 1'b0 :
                          (ack_mode < 5)  ? 1'b1 : ($urandom_range(0, 2) == 0);
            end else begin
                bus_ack = ($urandom_range(0, 5) == 0);
            end
            bus_rdata = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
